// File: rtl/xsimbus_master_port_pkg.sv
// Shared xSimBus encodings for the master port: select modes, R/W flag,
// reset level, bus widths and the 2-bit port FSM state codes.
package xsimbus_master_port_pkg;

    localparam logic RST_ENABLE = 1'b1;

    localparam int MEM_ADDR_BUS_WIDTH = 32;
    localparam int MEM_BYTE_BUS_W     = 8;

    localparam logic RW_INOUT_W = 1'b1;
    localparam logic RW_INOUT_R = 1'b0;

    typedef enum logic [1:0] {
        SELECT_AS_NONE   = 2'b00,
        SELECT_AS_MASTER = 2'b01,
        SELECT_AS_DEVICE = 2'b10
    } select_mode_e;

    typedef enum logic [1:0] {
        XSIM_PORT_IDLE = 2'b00,
        XSIM_PORT_REQ  = 2'b01,
        XSIM_PORT_XFER = 2'b10,
        XSIM_PORT_RESP = 2'b11
    } port_state_e;

endpackage

// File: rtl/xsimbus_master_port_if.sv
// Core-side request/response and bus-side signals of one xSimBus master slot.
// The master modport is the port itself; slave is the core plus bus environment.
interface xsimbus_master_port_if
    import xsimbus_master_port_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_BUS_WIDTH,
    parameter int DATA_W = MEM_BYTE_BUS_W
) ();

    logic              req_valid_in;
    logic              req_ready_out;
    logic              req_we_in;
    logic [ADDR_W-1:0] req_addr_in;
    logic [DATA_W-1:0] req_wdata_in;

    logic              rsp_valid_out;
    logic              rsp_ready_in;
    logic [DATA_W-1:0] rsp_rdata_out;
    logic              rsp_err_out;

    logic              bus_req_out;
    logic              bus_rw_out;
    logic [ADDR_W-1:0] bus_addr_out;
    logic [DATA_W-1:0] bus_data_out;
    select_mode_e      bus_select_in;
    logic [DATA_W-1:0] bus_data_in;

    modport master (
        input  req_valid_in, req_we_in, req_addr_in, req_wdata_in,
        input  rsp_ready_in, bus_select_in, bus_data_in,
        output req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out,
        output bus_req_out, bus_rw_out, bus_addr_out, bus_data_out
    );

    modport slave (
        output req_valid_in, req_we_in, req_addr_in, req_wdata_in,
        output rsp_ready_in, bus_select_in, bus_data_in,
        input  req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out,
        input  bus_req_out, bus_rw_out, bus_addr_out, bus_data_out
    );

endinterface

// File: rtl/xsimbus_wait_cnt.sv
// Grant-wait counter with limit compare; built only with XSIMBUS_TIMEOUT_EN.
// o_limit is high when the counter has reached LIMIT-1.
`ifdef XSIMBUS_TIMEOUT_EN
module xsimbus_wait_cnt
    import xsimbus_master_port_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_limit
);

    localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_limit = (r_cnt == LIMIT_M1);

endmodule
`endif

// File: rtl/xsimbus_master_port.sv
// xSimBus master-side front end: one core byte load/store becomes one bus
// transaction with a single response beat. Grant timeout via XSIMBUS_TIMEOUT_EN.
module xsimbus_master_port
    import xsimbus_master_port_pkg::*;
#(
    parameter int MASTER_ID   = 0,
    parameter int ADDR_W      = MEM_ADDR_BUS_WIDTH,
    parameter int DATA_W      = MEM_BYTE_BUS_W,
    parameter int TIMEOUT_CYC = 16
) (
    input logic                   clk,
    input logic                   rst,
    xsimbus_master_port_if.master bus_if
);

    port_state_e       r_state;
    port_state_e       w_next_state;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_grant;
    logic              w_timeout;
    logic              w_unused_cfg;

    // The slot index only matters to the arbiter wiring outside this block.
    assign w_unused_cfg = (MASTER_ID == 31) | (TIMEOUT_CYC == 0);

    assign w_accept = bus_if.req_valid_in && (r_state == XSIM_PORT_IDLE);
    assign w_grant  = (r_state == XSIM_PORT_REQ) &&
                      (bus_if.bus_select_in == SELECT_AS_MASTER);

`ifdef XSIMBUS_TIMEOUT_EN
    logic w_limit;

    xsimbus_wait_cnt #(
        .LIMIT   (TIMEOUT_CYC)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept),
        .i_inc   (r_state == XSIM_PORT_REQ),
        .o_limit (w_limit)
    );

    assign w_timeout = (r_state == XSIM_PORT_REQ) && w_limit && !w_grant;
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state <= XSIM_PORT_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            XSIM_PORT_IDLE: if (w_accept)  w_next_state = XSIM_PORT_REQ;
            XSIM_PORT_REQ: begin
                if (w_grant)        w_next_state = XSIM_PORT_XFER;
                else if (w_timeout) w_next_state = XSIM_PORT_RESP;
            end
            XSIM_PORT_XFER: w_next_state = XSIM_PORT_RESP;
            XSIM_PORT_RESP: if (bus_if.rsp_ready_in) w_next_state = XSIM_PORT_IDLE;
            default:        w_next_state = XSIM_PORT_IDLE;
        endcase
    end

    // Request fields are frozen at acceptance; response fields change only
    // in XFER or on timeout, so they stay stable throughout RESP.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= bus_if.req_we_in;
                r_addr  <= bus_if.req_addr_in;
                r_wdata <= bus_if.req_wdata_in;
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
            if (r_state == XSIM_PORT_XFER) begin
                r_rdata <= r_we ? '0 : bus_if.bus_data_in;
            end
            if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    // NOTE: every output gets a default before the case, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        bus_if.req_ready_out = 1'b0;
        bus_if.rsp_valid_out = 1'b0;
        bus_if.bus_req_out   = 1'b0;
        bus_if.bus_rw_out    = RW_INOUT_R;
        bus_if.bus_addr_out  = '0;
        bus_if.bus_data_out  = '0;
        case (r_state)
            XSIM_PORT_IDLE: bus_if.req_ready_out = 1'b1;
            XSIM_PORT_REQ, XSIM_PORT_XFER: begin
                bus_if.bus_req_out  = 1'b1;
                bus_if.bus_rw_out   = r_we ? RW_INOUT_W : RW_INOUT_R;
                bus_if.bus_addr_out = r_addr;
                bus_if.bus_data_out = r_wdata;
            end
            XSIM_PORT_RESP: bus_if.rsp_valid_out = 1'b1;
            default: ;
        endcase
        bus_if.rsp_rdata_out = r_rdata;
        bus_if.rsp_err_out   = r_err;
    end

endmodule

// File: tb/tb_xsimbus_master_port.sv
// Directed self-checking bench for xsimbus_master_port (MASTER_ID=2,
// TIMEOUT_CYC=4); the timeout scenarios run when XSIMBUS_TIMEOUT_EN is defined.
module tb_xsimbus_master_port;
    import xsimbus_master_port_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    xsimbus_master_port_if #(.ADDR_W(32), .DATA_W(8)) bus_if ();

    xsimbus_master_port #(
        .MASTER_ID   (2),
        .ADDR_W      (32),
        .DATA_W      (8),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst                  = 1'b1;
        bus_if.req_valid_in  = 1'b0;
        bus_if.req_we_in     = 1'b0;
        bus_if.req_addr_in   = 32'h0;
        bus_if.req_wdata_in  = 8'h0;
        bus_if.rsp_ready_in  = 1'b0;
        bus_if.bus_select_in = SELECT_AS_NONE;
        bus_if.bus_data_in   = 8'h0;

        // Reset state
        tick();
        tick();
        check("rst_req_ready", bus_if.req_ready_out, 1);
        check("rst_rsp_valid", bus_if.rsp_valid_out, 0);
        check("rst_bus_req",   bus_if.bus_req_out,   0);
        check("rst_bus_rw",    bus_if.bus_rw_out,    0);
        check("rst_bus_addr",  bus_if.bus_addr_out,  0);
        check("rst_bus_data",  bus_if.bus_data_out,  0);
        check("rst_rdata",     bus_if.rsp_rdata_out, 0);
        check("rst_err",       bus_if.rsp_err_out,   0);
        rst = 1'b0;
        tick();

        // 1: read, immediate grant, then 4 cycles of response backpressure
        bus_if.req_valid_in = 1'b1;
        bus_if.req_we_in    = 1'b0;
        bus_if.req_addr_in  = 32'h0000_0104;
        check("t1_ready_before", bus_if.req_ready_out, 1);
        tick();
        bus_if.req_valid_in  = 1'b0;
        bus_if.req_addr_in   = 32'hDEAD_BEEF;
        check("t1_req_bus_req",  bus_if.bus_req_out,   1);
        check("t1_req_addr",     bus_if.bus_addr_out,  32'h0000_0104);
        check("t1_req_rw",       bus_if.bus_rw_out,    RW_INOUT_R);
        check("t1_req_ready",    bus_if.req_ready_out, 0);
        check("t1_req_rsp",      bus_if.rsp_valid_out, 0);
        bus_if.bus_select_in = SELECT_AS_MASTER;
        tick();
        bus_if.bus_select_in = SELECT_AS_NONE;
        bus_if.bus_data_in   = 8'hA5;
        check("t1_xfer_bus_req", bus_if.bus_req_out,   1);
        check("t1_xfer_addr",    bus_if.bus_addr_out,  32'h0000_0104);
        check("t1_xfer_rsp",     bus_if.rsp_valid_out, 0);
        tick();
        bus_if.bus_data_in   = 8'h11;
        for (int i = 0; i < 4; i++) begin
            check("t1_bp_rsp_valid", bus_if.rsp_valid_out, 1);
            check("t1_bp_rdata",     bus_if.rsp_rdata_out, 8'hA5);
            check("t1_bp_err",       bus_if.rsp_err_out,   0);
            check("t1_bp_req_ready", bus_if.req_ready_out, 0);
            check("t1_bp_bus_req",   bus_if.bus_req_out,   0);
            tick();
        end
        bus_if.rsp_ready_in = 1'b1;
        check("t1_hs_rsp_valid", bus_if.rsp_valid_out, 1);
        check("t1_hs_req_ready", bus_if.req_ready_out, 0);
        tick();
        bus_if.rsp_ready_in = 1'b0;
        check("t1_done_rsp",     bus_if.rsp_valid_out, 0);
        check("t1_done_ready",   bus_if.req_ready_out, 1);

        // 2: write with rsp_ready already high on RESP entry
        bus_if.req_valid_in = 1'b1;
        bus_if.req_we_in    = 1'b1;
        bus_if.req_addr_in  = 32'h0000_0200;
        bus_if.req_wdata_in = 8'h3C;
        bus_if.rsp_ready_in = 1'b1;
        tick();
        bus_if.req_valid_in  = 1'b0;
        bus_if.req_wdata_in  = 8'hFF;
        bus_if.req_we_in     = 1'b0;
        check("t2_req_rw",       bus_if.bus_rw_out,   RW_INOUT_W);
        check("t2_req_data",     bus_if.bus_data_out, 8'h3C);
        check("t2_req_addr",     bus_if.bus_addr_out, 32'h0000_0200);
        bus_if.bus_select_in = SELECT_AS_MASTER;
        bus_if.bus_data_in   = 8'h77;
        tick();
        bus_if.bus_select_in = SELECT_AS_NONE;
        check("t2_xfer_rw",      bus_if.bus_rw_out,   RW_INOUT_W);
        check("t2_xfer_data",    bus_if.bus_data_out, 8'h3C);
        check("t2_xfer_bus_req", bus_if.bus_req_out,  1);
        tick();
        check("t2_rsp_valid",    bus_if.rsp_valid_out, 1);
        check("t2_rsp_rdata",    bus_if.rsp_rdata_out, 0);
        check("t2_rsp_err",      bus_if.rsp_err_out,   0);
        tick();
        bus_if.rsp_ready_in = 1'b0;
        check("t2_done_rsp",     bus_if.rsp_valid_out, 0);
        check("t2_done_ready",   bus_if.req_ready_out, 1);

`ifndef XSIMBUS_TIMEOUT_EN
        // 3: contention, 5 ungranted REQ cycles (one showing SelectAsDevice)
        bus_if.req_valid_in = 1'b1;
        bus_if.req_we_in    = 1'b0;
        bus_if.req_addr_in  = 32'h0000_0300;
        tick();
        bus_if.req_valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_if.bus_select_in = (i == 2) ? SELECT_AS_DEVICE : SELECT_AS_NONE;
            check("t3_wait_bus_req", bus_if.bus_req_out,   1);
            check("t3_wait_addr",    bus_if.bus_addr_out,  32'h0000_0300);
            check("t3_wait_rw",      bus_if.bus_rw_out,    RW_INOUT_R);
            check("t3_wait_rsp",     bus_if.rsp_valid_out, 0);
            tick();
        end
        check("t3_grant_bus_req", bus_if.bus_req_out, 1);
        bus_if.bus_select_in = SELECT_AS_MASTER;
        tick();
        bus_if.bus_select_in = SELECT_AS_DEVICE;
        bus_if.bus_data_in   = 8'h5A;
        check("t3_xfer_bus_req", bus_if.bus_req_out,   1);
        check("t3_xfer_rsp",     bus_if.rsp_valid_out, 0);
        bus_if.rsp_ready_in  = 1'b1;
        tick();
        bus_if.bus_select_in = SELECT_AS_NONE;
        check("t3_rsp_valid",    bus_if.rsp_valid_out, 1);
        check("t3_rsp_rdata",    bus_if.rsp_rdata_out, 8'h5A);
        tick();
        bus_if.rsp_ready_in = 1'b0;
        check("t3_done_rsp",     bus_if.rsp_valid_out, 0);
        tick();
        check("t3_single_rsp",   bus_if.rsp_valid_out, 0);
        check("t3_idle_bus_req", bus_if.bus_req_out,   0);
`endif

        // 5: reset pulse while in REQ aborts the transaction
        bus_if.req_valid_in = 1'b1;
        bus_if.req_we_in    = 1'b0;
        bus_if.req_addr_in  = 32'h0000_0400;
        tick();
        bus_if.req_valid_in = 1'b0;
        check("t5_req_bus_req", bus_if.bus_req_out, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.bus_select_in = SELECT_AS_MASTER;
        check("t5_rst_bus_req",   bus_if.bus_req_out,   0);
        check("t5_rst_req_ready", bus_if.req_ready_out, 1);
        check("t5_rst_rsp",       bus_if.rsp_valid_out, 0);
        tick();
        bus_if.bus_select_in = SELECT_AS_NONE;
        check("t5_after_rsp",     bus_if.rsp_valid_out, 0);
        check("t5_after_bus_req", bus_if.bus_req_out,   0);
        tick();
        check("t5_after2_rsp",    bus_if.rsp_valid_out, 0);

`ifdef XSIMBUS_TIMEOUT_EN
        // 6a: never granted, limit after 4 REQ cycles
        bus_if.req_valid_in = 1'b1;
        bus_if.req_addr_in  = 32'h0000_0500;
        bus_if.bus_data_in  = 8'h99;
        tick();
        bus_if.req_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t6_wait_bus_req", bus_if.bus_req_out,   1);
            check("t6_wait_rsp",     bus_if.rsp_valid_out, 0);
            tick();
        end
        check("t6_to_bus_req",   bus_if.bus_req_out,   0);
        check("t6_to_rsp_valid", bus_if.rsp_valid_out, 1);
        check("t6_to_err",       bus_if.rsp_err_out,   1);
        check("t6_to_rdata",     bus_if.rsp_rdata_out, 0);
        bus_if.rsp_ready_in = 1'b1;
        tick();
        bus_if.rsp_ready_in = 1'b0;
        check("t6_to_done", bus_if.rsp_valid_out, 0);

        // 6b: grant on the limit cycle wins
        bus_if.req_valid_in = 1'b1;
        bus_if.req_addr_in  = 32'h0000_0504;
        tick();
        bus_if.req_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6g_wait_bus_req", bus_if.bus_req_out, 1);
            tick();
        end
        bus_if.bus_select_in = SELECT_AS_MASTER;
        tick();
        bus_if.bus_select_in = SELECT_AS_NONE;
        bus_if.bus_data_in   = 8'h66;
        check("t6g_xfer_bus_req", bus_if.bus_req_out,   1);
        check("t6g_xfer_rsp",     bus_if.rsp_valid_out, 0);
        tick();
        check("t6g_rsp_valid", bus_if.rsp_valid_out, 1);
        check("t6g_rsp_err",   bus_if.rsp_err_out,   0);
        check("t6g_rsp_rdata", bus_if.rsp_rdata_out, 8'h66);
        bus_if.rsp_ready_in = 1'b1;
        tick();
        bus_if.rsp_ready_in = 1'b0;
        check("t6g_done", bus_if.req_ready_out, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
